// File: rtl/canvas_pkg.sv
// Shared types and helpers for the canvas compositor: coordinate width,
// controller states and the stored-to-8-bit channel expansion.
package canvas_pkg;

  localparam int unsigned COORD_W        = 11;
  localparam int unsigned PKG_COLOR_BITS = 3;

  typedef enum logic {CLEAR, RUN} state_t;

  typedef logic [3*PKG_COLOR_BITS-1:0] pixel_t;

  // v holds a 'bits'-wide channel in its LSBs; output is MSB-aligned and
  // filled by repeating the channel bits from the top down.
  function automatic logic [7:0] expand_chan(input logic [7:0] v, input int unsigned bits);
    logic [7:0] r;
    logic [2:0] idx;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = 3'(bits - 1 - (k % bits));
      r[3'(7 - k)] = v[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/canvas_compositor_cursor.sv
// Crosshair hit detection for N cursors; lowest-index cursor wins on overlap.
module cursor_overlay
  import canvas_pkg::*;
#(
  parameter int unsigned N_CURSORS  = 2,
  parameter int unsigned CURSOR_ARM = 5
) (
  input  logic signed [11:0]                 i_px,
  input  logic signed [11:0]                 i_py,
  input  logic        [COORD_W*N_CURSORS-1:0] i_cursor_x,
  input  logic        [COORD_W*N_CURSORS-1:0] i_cursor_y,
  input  logic        [N_CURSORS-1:0]         i_cursor_en,
  input  logic        [24*N_CURSORS-1:0]      i_cursor_color,
  output logic                                o_hit,
  output logic        [23:0]                  o_color
);

  localparam logic signed [11:0] ARM = 12'(CURSOR_ARM);

  logic signed [11:0] w_dx, w_dy, w_adx, w_ady;

  always_comb begin
    o_hit   = 1'b0;
    o_color = '0;
    w_dx    = '0;
    w_dy    = '0;
    w_adx   = '0;
    w_ady   = '0;
    for (int unsigned i = 0; i < N_CURSORS; i++) begin
      w_dx  = i_px - $signed({1'b0, i_cursor_x[i*COORD_W +: COORD_W]});
      w_dy  = i_py - $signed({1'b0, i_cursor_y[i*COORD_W +: COORD_W]});
      w_adx = w_dx[11] ? -w_dx : w_dx;
      w_ady = w_dy[11] ? -w_dy : w_dy;
      if (i_cursor_en[i] && !o_hit &&
          ((w_dx == '0 && w_ady <= ARM) || (w_dy == '0 && w_adx <= ARM))) begin
        o_hit   = 1'b1;
        o_color = i_cursor_color[i*24 +: 24];
      end
    end
  end

endmodule

// File: rtl/canvas_compositor.sv
// Frame-buffer front end: canvas clear/brush write arbitration, raster read
// addressing with RAM-latency alignment, cursor overlay and VGA colour output.
module canvas_compositor
  import canvas_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned H_OFFSET   = 145,
  parameter int unsigned V_OFFSET   = 36,
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned N_CURSORS  = 2,
  parameter int unsigned CURSOR_ARM = 5,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic [COORD_W-1:0]            vga_x,
  input  logic [COORD_W-1:0]            vga_y,
  input  logic                          vga_active,
  input  logic [COORD_W*N_CURSORS-1:0]  cursor_x,
  input  logic [COORD_W*N_CURSORS-1:0]  cursor_y,
  input  logic [N_CURSORS-1:0]          cursor_en,
  input  logic [24*N_CURSORS-1:0]       cursor_color,
  input  logic                          clear_req,
  input  logic [3*COLOR_BITS-1:0]       clear_color,
  output logic                          clear_busy,
  input  logic                          brush_we,
  input  logic [ADDR_W-1:0]             brush_addr,
  input  logic [3*COLOR_BITS-1:0]       brush_data,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_write_addr,
  output logic [3*COLOR_BITS-1:0]       fb_write_data,
  output logic                          fb_re,
  output logic [ADDR_W-1:0]             fb_read_addr,
  input  logic [3*COLOR_BITS-1:0]       fb_data_in,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B
);

  localparam int unsigned       PW         = 3*COLOR_BITS;
  localparam int unsigned       L          = RD_LATENCY;
  localparam int unsigned       PIXELS     = H_ACTIVE*V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIXELS-1);
  localparam logic [ADDR_W:0]   PIXELS_EXT = (ADDR_W+1)'(PIXELS);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
  logic                r_busy;
  logic                r_we, w_we_next;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_next;
  logic [PW-1:0]       r_wdata, w_wdata_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_we_next    = 1'b0;
    w_waddr_next = brush_addr;
    w_wdata_next = brush_data;
    case (r_state)
      CLEAR: begin
        w_we_next    = 1'b1;
        w_waddr_next = r_cnt;
        w_wdata_next = clear_color;
        if (r_cnt == LAST_ADDR) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_we_next = brush_we && ({1'b0, brush_addr} < PIXELS_EXT);
        if (clear_req) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = CLEAR;
    endcase
  end

  // busy is registered from the state so it brackets the clear writes as seen on fb_*
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (r_state == CLEAR);
      r_we    <= w_we_next;
      r_waddr <= w_waddr_next;
      r_wdata <= w_wdata_next;
    end
  end

  assign clear_busy    = r_busy;
  assign fb_we         = r_we;
  assign fb_write_addr = r_waddr;
  assign fb_write_data = r_wdata;

  logic signed [11:0] w_px, w_py;
  logic               w_in_win;

  assign w_px     = $signed({1'b0, vga_x}) - $signed(12'(H_OFFSET));
  assign w_py     = $signed({1'b0, vga_y}) - $signed(12'(V_OFFSET));
  assign w_in_win = vga_active && !w_px[11] && !w_py[11] &&
                    (w_px < $signed(12'(H_ACTIVE))) && (w_py < $signed(12'(V_ACTIVE)));

  assign fb_re        = w_in_win;
  assign fb_read_addr = w_in_win ?
                        (ADDR_W'(w_py[10:0]) * ADDR_W'(H_ACTIVE) + ADDR_W'(w_px[10:0])) : '0;

  logic        w_cur_hit;
  logic [23:0] w_cur_color;

  cursor_overlay #(
    .N_CURSORS  (N_CURSORS),
    .CURSOR_ARM (CURSOR_ARM)
  ) u_cursor (
    .i_px           (w_px),
    .i_py           (w_py),
    .i_cursor_x     (cursor_x),
    .i_cursor_y     (cursor_y),
    .i_cursor_en    (cursor_en),
    .i_cursor_color (cursor_color),
    .o_hit          (w_cur_hit),
    .o_color        (w_cur_color)
  );

  // Shift registers aligning raster-side decisions with fb_data_in; tail is bit L-1.
  logic [L-1:0]    r_act_d, r_win_d, r_hit_d;
  logic [24*L-1:0] r_col_d;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_act_d <= '0;
      r_win_d <= '0;
      r_hit_d <= '0;
      r_col_d <= '0;
    end else begin
      r_act_d <= (r_act_d << 1) | L'(vga_active);
      r_win_d <= (r_win_d << 1) | L'(w_in_win);
      r_hit_d <= (r_hit_d << 1) | L'(w_cur_hit && w_in_win);
      r_col_d <= (r_col_d << 24) | (24*L)'(w_cur_color);
    end
  end

  logic [23:0] w_exp, w_pix, r_pix;

  assign w_exp = {expand_chan(8'(fb_data_in[PW-1 -: COLOR_BITS]), COLOR_BITS),
                  expand_chan(8'(fb_data_in[2*COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS),
                  expand_chan(8'(fb_data_in[COLOR_BITS-1:0]), COLOR_BITS)};

  always_comb begin
    w_pix = '0;
    if (r_state == RUN && r_act_d[L-1]) begin
      if (r_hit_d[L-1])      w_pix = r_col_d[24*L-1 -: 24];
      else if (r_win_d[L-1]) w_pix = w_exp;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_pix <= '0;
    else          r_pix <= w_pix;
  end

  assign VGA_R = r_pix[23:16];
  assign VGA_G = r_pix[15:8];
  assign VGA_B = r_pix[7:0];

endmodule

// File: tb/tb_canvas_compositor.sv
// Directed bench for canvas_compositor (8x4 canvas, offsets 2/1, RD_LATENCY=2)
// with queue-based scoreboards for the write port and the VGA pixel stream.
module tb_canvas_compositor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] vga_x = '0, vga_y = '0;
  logic        vga_active = 1'b0;
  logic [21:0] cursor_x = '0, cursor_y = '0;
  logic [1:0]  cursor_en = '0;
  logic [47:0] cursor_color = {24'hABCDEF, 24'h123456};
  logic        clear_req = 1'b0;
  logic [8:0]  clear_color = 9'h15A;
  logic        clear_busy;
  logic        brush_we = 1'b0;
  logic [5:0]  brush_addr = '0;
  logic [8:0]  brush_data = '0;
  logic        fb_we, fb_re;
  logic [5:0]  fb_write_addr, fb_read_addr;
  logic [8:0]  fb_write_data, fb_data_in;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  always #5 clk = ~clk;

  canvas_compositor #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_OFFSET(2), .V_OFFSET(1), .COLOR_BITS(3),
    .N_CURSORS(2), .CURSOR_ARM(5), .RD_LATENCY(2), .ADDR_W(6)
  ) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .vga_x(vga_x), .vga_y(vga_y),
    .vga_active(vga_active), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_en(cursor_en), .cursor_color(cursor_color), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .brush_we(brush_we),
    .brush_addr(brush_addr), .brush_data(brush_data), .fb_we(fb_we),
    .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data), .fb_re(fb_re),
    .fb_read_addr(fb_read_addr), .fb_data_in(fb_data_in),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  // RAM model with 2-cycle read latency whose content equals its address
  logic [8:0] ram_q1 = '0, ram_q2 = '0;
  always @(posedge clk) begin
    ram_q1 <= 9'(fb_read_addr);
    ram_q2 <= ram_q1;
  end
  assign fb_data_in = ram_q2;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [8:0] data;
    logic       busy;
  } wexp_t;

  wexp_t       wq[$];
  logic [23:0] vq[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  bit          m_clr = 1'b1;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [23:0] pix_model();
    int px, py, cx, cy, dx, dy;
    bit win;
    logic [8:0] d;
    px = int'(vga_x) - 2;
    py = int'(vga_y) - 1;
    if (!vga_active) return '0;
    win = (px >= 0) && (px < 8) && (py >= 0) && (py < 4);
    if (!win) return '0;
    for (int i = 0; i < 2; i++) begin
      cx = int'(cursor_x[i*11 +: 11]);
      cy = int'(cursor_y[i*11 +: 11]);
      dx = px - cx;
      dy = py - cy;
      if (cursor_en[i] && ((dx == 0 && dy >= -5 && dy <= 5) || (dy == 0 && dx >= -5 && dx <= 5)))
        return cursor_color[i*24 +: 24];
    end
    d = 9'(py*8 + px);
    return {exp3(d[8:6]), exp3(d[5:3]), exp3(d[2:0])};
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, ".fb_we"}, 32'(fb_we), 32'd0);
    chk({tag, ".fb_write_addr"}, 32'(fb_write_addr), 32'd0);
    chk({tag, ".fb_write_data"}, 32'(fb_write_data), 32'd0);
    chk({tag, ".clear_busy"}, 32'(clear_busy), 32'd1);
    chk({tag, ".vga"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
  endtask

  // One clock: push expectations for the current inputs, advance, pop and compare.
  task automatic step();
    wexp_t e;
    logic [23:0] p;
    if (!reset_n) begin
      e = '{1'b0, 6'd0, 9'd0, 1'b1};
      m_clr = 1'b1;
      m_cnt = 0;
      vq.delete();
    end else if (m_clr) begin
      e = '{1'b1, 6'(m_cnt), clear_color, 1'b1};
      if (m_cnt == 31) begin
        m_clr = 1'b0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      e = '{brush_we && (int'(brush_addr) < 32), brush_addr, brush_data, 1'b0};
      if (clear_req) begin
        m_clr = 1'b1;
        m_cnt = 0;
      end
    end
    wq.push_back(e);
    if (reset_n) vq.push_back(pix_model());
    @(posedge clk);
    #1;
    e = wq.pop_front();
    chk("fb_we", 32'(fb_we), 32'(e.we));
    if (e.we) begin
      chk("fb_write_addr", 32'(fb_write_addr), 32'(e.addr));
      chk("fb_write_data", 32'(fb_write_data), 32'(e.data));
    end
    chk("clear_busy", 32'(clear_busy), 32'(e.busy));
    if (vq.size() == 3) begin
      p = vq.pop_front();
      chk("vga_pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'(p));
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [1:0] en;
    int         c1x;
    int         c1y;
  } cur_t;

  cur_t ctab[9] = '{
    '{2, 4, 2'b01, 0, 0},
    '{9, 1, 2'b01, 0, 0},
    '{7, 1, 2'b01, 0, 0},
    '{8, 1, 2'b01, 0, 0},
    '{9, 4, 2'b01, 0, 0},
    '{1, 1, 2'b01, 0, 0},
    '{4, 1, 2'b11, 0, 0},
    '{2, 3, 2'b10, 0, 0},
    '{9, 1, 2'b11, 7, 3}
  };

  initial begin
    int guard;
    #1 reset_n = 1'b0;
    #2 check_reset_values("por");
    step();
    step();
    reset_n = 1'b1;

    // full clear; a brush strobe held throughout must never reach the write port
    brush_we = 1'b1; brush_addr = 6'd3; brush_data = 9'h1FF;
    for (int i = 0; i < 32; i++) step();
    brush_we = 1'b0;
    step();

    brush_we = 1'b1; brush_addr = 6'd5;  brush_data = 9'h1A3; step();
    brush_addr = 6'd32; brush_data = 9'h0AA; step();
    brush_addr = 6'd31; brush_data = 9'h0C5; step();
    brush_we = 1'b0; step();

    vga_active = 1'b1; vga_x = 11'd4; vga_y = 11'd2;
    #1;
    chk("fb_re_in", 32'(fb_re), 32'd1);
    chk("fb_read_addr_10", 32'(fb_read_addr), 32'd10);
    step();
    vga_x = 11'd1;
    #1;
    chk("fb_re_border", 32'(fb_re), 32'd0);
    chk("fb_read_addr_border", 32'(fb_read_addr), 32'd0);
    step();
    vga_active = 1'b0;
    for (int i = 0; i < 3; i++) step();

    vga_active = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vga_x = 11'(ctab[i].x);
      vga_y = 11'(ctab[i].y);
      cursor_en = ctab[i].en;
      cursor_x = {11'(ctab[i].c1x), 11'd0};
      cursor_y = {11'(ctab[i].c1y), 11'd0};
      step();
    end
    vga_active = 1'b0;
    cursor_en = '0;
    for (int i = 0; i < 3; i++) step();

    // brush and clear_req together, then a clear_req mid-clear that must be ignored
    brush_we = 1'b1; brush_addr = 6'd7; brush_data = 9'h0F0; clear_req = 1'b1;
    step();
    brush_we = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    clear_req = 1'b1; step(); clear_req = 1'b0;
    guard = 0;
    while (m_clr && guard < 40) begin step(); guard++; end
    chk("clear_done_bound", 32'(m_clr), 32'd0);
    step();

    // reset in the middle of a clear at cnt=17
    clear_req = 1'b1; step(); clear_req = 1'b0;
    guard = 0;
    while (m_cnt != 17 && guard < 40) begin step(); guard++; end
    chk("cnt17_bound", 32'(m_cnt), 32'd17);
    reset_n = 1'b0;
    #1 check_reset_values("mid_clear_rst");
    step();
    step();
    reset_n = 1'b1;
    guard = 0;
    while (m_clr && guard < 40) begin step(); guard++; end
    chk("reclear_done_bound", 32'(m_clr), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_compositor.md
# canvas_compositor

Parametrised frame-buffer front end for the paint canvas. It sits between the VGA timing generator, the dual-port canvas RAM, the brush/cursor logic and the VGA DAC pins. It owns the canvas clear sequence, on reset and on request, and arbitrates brush writes against it. It generates frame-buffer read addresses, compensates RAM read latency, and overlays N crosshair cursors with per-cursor colour. It expands stored RGB to 8 bits per channel using bit replication.

## Interface
Parameters:
- H_ACTIVE, 640: canvas width in pixels.
- V_ACTIVE, 480: canvas height in pixels.
- H_OFFSET, 145: vga_x of canvas column 0.
- V_OFFSET, 36: vga_y of canvas row 0.
- COLOR_BITS, 3: stored bits per channel; stored pixel is 3*COLOR_BITS wide, R in the MSBs.
- N_CURSORS, 2: number of crosshair overlays.
- CURSOR_ARM, 5: arm length in pixels; each arm is 2*CURSOR_ARM+1 pixels long.
- RD_LATENCY, 1: RAM read latency in cycles, 1..4.
- ADDR_W, 19: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vga_x, vga_y  in  11 each  raster position from the timing generator.
- vga_active  in  1  raster is in the visible region.
- cursor_x, cursor_y  in  11*N_CURSORS each  canvas-space cursor positions; cursor i occupies bits [11i+10:11i].
- cursor_en  in  N_CURSORS  per-cursor overlay enable.
- cursor_color  in  24*N_CURSORS  per-cursor {R,G,B} colour, 8 bits per channel.
- clear_req  in  1  single-cycle pulse requesting a canvas clear.
- clear_color  in  3*COLOR_BITS  value written to every pixel during a clear.
- clear_busy  out  1  high while a clear is in progress.
- brush_we  in  1  brush write strobe.
- brush_addr  in  ADDR_W  brush write address.
- brush_data  in  3*COLOR_BITS  brush write data.
- fb_we  out  1  registered RAM write enable.
- fb_write_addr  out  ADDR_W  registered RAM write address.
- fb_write_data  out  3*COLOR_BITS  registered RAM write data.
- fb_re  out  1  RAM read enable.
- fb_read_addr  out  ADDR_W  RAM read address.
- fb_data_in  in  3*COLOR_BITS  RAM read data.
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour.

## Operation
- State machine has two states, CLEAR and RUN. Reset enters CLEAR with the clear counter at 0.
- CLEAR:
  - Each cycle writes clear_color to address cnt, then increments cnt.
  - After the write to H_ACTIVE*V_ACTIVE-1, the next state is RUN.
  - Brush writes are dropped while in CLEAR.
  - clear_req is ignored while in CLEAR.
  - VGA outputs are forced to 0.
- RUN:
  - brush_we with brush_addr < H_ACTIVE*V_ACTIVE is forwarded to the write port.
  - Out-of-range brush addresses are dropped.
  - clear_req moves the machine to CLEAR on the next cycle with cnt=0.
  - If brush_we and clear_req arrive in the same cycle, the brush write is still issued.
- Reset asserted mid-clear restarts the clear from address 0 after release.
- Canvas window: in_win = vga_active and H_OFFSET ≤ vga_x < H_OFFSET+H_ACTIVE and V_OFFSET ≤ vga_y < V_OFFSET+V_ACTIVE.
- Read port:
  - fb_re = in_win.
  - fb_read_addr = (vga_y-V_OFFSET)*H_ACTIVE + (vga_x-H_OFFSET), computed combinationally.
  - When in_win=0, fb_read_addr is 0.
- Cursor hit, for cursor i with cx, cy taken from canvas coordinates:
  - hit_i = cursor_en[i] and ((px==cx and |py-cy| ≤ CURSOR_ARM) or (py==cy and |px-cx| ≤ CURSOR_ARM)).
  - Use signed 12-bit arithmetic so there is no wrap-around near 0.
  - The lowest index wins when cursors overlap.
- Pixel select, in priority order:
  - not vga_active: 0.
  - any cursor hit inside the window: that cursor's colour.
  - in_win: expanded RAM data.
  - otherwise (border): 0.
- Expansion: each channel is MSB-aligned, then its bits are repeated to fill 8 bits. With COLOR_BITS=3: 3'b101 → 8'b10110110, 3'b111 → 8'hFF, 0 → 0.

## Timing
- Reset values:
  - clear_busy=1.
  - fb_we=0; fb_write_addr=0; fb_write_data=0.
  - VGA_R, VGA_G, VGA_B = 0.
  - All pipeline registers 0.
- Write port latency is 1 cycle.
  - First clear write appears on the first rising edge after reset_n deasserts.
  - A full clear takes exactly H_ACTIVE*V_ACTIVE cycles.
  - clear_busy falls in the cycle after the last clear write.
- Display latency is RD_LATENCY+1 cycles from vga_x/vga_y/vga_active to VGA_*.
  - in_win, the cursor-hit result and vga_active are delayed RD_LATENCY stages to align with fb_data_in.
  - A final output register follows.
- Cursor inputs are sampled together with vga_x; a cursor move takes effect on the next pixel.

## Structure
- Shared package canvas_pkg holds:
  - coordinate width 11.
  - state enum {CLEAR, RUN}.
  - pixel type of width 3*COLOR_BITS.
  - the channel expansion function.
- One sub-module, cursor_overlay: N_CURSORS hit detectors plus priority select. Outputs a hit flag and a 24-bit colour.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4, offsets 2/1 unless noted.
- Reset release: fb_we=1 at addresses 0..31 on consecutive cycles with clear_color. clear_busy falls after the 32nd write. A brush_we during the clear never reaches fb_we.
- RUN with brush_we, addr 5, data 9'h1A3: next cycle fb_we=1, address 5, data 9'h1A3. Address 32 produces no write.
- Read path with RD_LATENCY=2 (model RAM returns data = address): vga_x=4, vga_y=2 → fb_read_addr=10, and VGA_* shows expanded 10 after 3 cycles. Expected: R=0, G=8'b00100100, B=8'b01001001.
- Cursor at (0,0), ARM=5: px=0, py=3 → cursor colour; px=7, py=0 → RAM colour; no false hit from underflow. Overlapping cursor 0 and cursor 1 → cursor 0's colour.
- clear_req in the same cycle as brush_we: brush write issued, then a clear from address 0 follows. A second clear_req mid-clear does not restart the clear.
- reset_n pulsed mid-clear at cnt=17: after release, the clear restarts at address 0. All outputs equal reset values while reset is low.
